// File: rtl/inv_share_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for the OPT1 shared
// negation path.
package inv_arb_pkg;

    localparam int INV_IN_W  = 8;
    localparam int INV_OUT_W = 9;
    localparam int TXN_CNT_W = 16;
    localparam int MAX_REQ   = 16;
    localparam int MAX_ID_W  = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // The scan wraps at MAX_REQ. Callers zero-extend their request vector,
    // so the unused upper slots are skipped and the order matches a mod-N scan.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                         input logic [MAX_ID_W-1:0] ptr);
        rr_pick_t            r;
        logic [MAX_ID_W-1:0] i;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            i = ptr + MAX_ID_W'(k);
            if (!r.found && valid[i]) begin
                r.found = 1'b1;
                r.idx   = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_share_arbiter_if.sv
// Requester/result bundle of the shared negation arbiter.
// A transfer happens on a cycle where both valid and ready are high.
// Once valid is raised, it is not gated by ready. Result data and id stay stable while valid is high and ready is low.
interface inv_share_arbiter_if #(parameter int NUM_REQ = 4);
    import inv_arb_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid_i;
    logic [INV_IN_W*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]          req_neg_i;
    logic [NUM_REQ-1:0]          req_ready_o;
    logic                        out_valid_o;
    logic [INV_OUT_W-1:0]        out_data_o;
    logic [ID_W-1:0]             out_id_o;
    logic                        out_ready_i;
    logic [TXN_CNT_W-1:0]        txn_cnt_o;
    logic                        cnt_clr_i;

    modport slave (
        input  req_valid_i, req_data_i, req_neg_i, out_ready_i, cnt_clr_i,
        output req_ready_o, out_valid_o, out_data_o, out_id_o, txn_cnt_o
    );

    modport master (
        output req_valid_i, req_data_i, req_neg_i, out_ready_i, cnt_clr_i,
        input  req_ready_o, out_valid_o, out_data_o, out_id_o, txn_cnt_o
    );

endinterface

// File: rtl/inv_share_arbiter_inv_converter_8.sv
// 8-bit signed negation into 9 bits. The extra bit keeps -(-128) representable.
module inv_converter_8 (
    input  logic [7:0] x,
    output logic [8:0] y
);

    assign y = -{x[7], x};

endmodule

// File: rtl/inv_share_arbiter_rr_arbiter.sv
// Reusable round-robin picker. The search starts at ptr and wraps modulo N.
module rr_arbiter
    import inv_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant_onehot,
    output logic [ID_W-1:0] grant_idx,
    output logic            found
);

    rr_pick_t pick;

    always_comb begin
        pick         = rr_pick(MAX_REQ'(req), MAX_ID_W'(ptr));
        found        = pick.found;
        grant_idx    = ID_W'(pick.idx);
        grant_onehot = '0;
        if (pick.found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/inv_share_arbiter.sv
// Shares one inv_converter_8 among NUM_REQ requesters through a round-robin
// grant. Results leave through a single-slot registered output.
module inv_share_arbiter
    import inv_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    inv_share_arbiter_if.slave       bus
);

    logic                 full;
    logic [INV_OUT_W-1:0] data_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      rr_ptr;
    logic [TXN_CNT_W-1:0] cnt_q;

    logic [NUM_REQ-1:0]   grant_onehot;
    logic [ID_W-1:0]      win;
    logic                 found;
    logic                 can_accept;
    logic                 accept;
    logic                 handshake;
    logic [INV_IN_W-1:0]  win_data;
    logic                 win_neg;
    logic [INV_OUT_W-1:0] neg_res;
    logic [INV_OUT_W-1:0] result;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req          (bus.req_valid_i),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (win),
        .found        (found)
    );

    // The slot can take a new result when it is empty or is being drained this cycle.
    assign can_accept      = !full || bus.out_ready_i;
    assign accept          = found && can_accept;
    assign handshake       = full && bus.out_ready_i;
    assign bus.req_ready_o = can_accept ? grant_onehot : '0;

    assign win_data = bus.req_data_i[int'(win)*INV_IN_W +: INV_IN_W];
    assign win_neg  = bus.req_neg_i[win];

    inv_converter_8 u_inv (
        .x (win_data),
        .y (neg_res)
    );

    assign result = win_neg ? neg_res : {win_data[INV_IN_W-1], win_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            full   <= 1'b1;
            data_q <= result;
            id_q   <= win;
            rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (handshake) begin
            full   <= 1'b0;
        end
    end

    // The clear wins over a handshake that lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr_i) begin
            cnt_q <= '0;
        end else if (handshake && (cnt_q != {TXN_CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out_valid_o = full;
    assign bus.out_data_o  = data_q;
    assign bus.out_id_o    = id_q;
    assign bus.txn_cnt_o   = cnt_q;

endmodule

// File: tb/tb_inv_share_arbiter.sv
// Bench for inv_share_arbiter: a queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_inv_share_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    inv_share_arbiter_if #(.NUM_REQ(N)) bus ();

    inv_share_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The reference model holds the output slot as a queue of {id, data} entries.
    logic [IDW+8:0] exp_q[$];
    int m_ptr = 0;
    int m_cnt = 0;
    int m_w;
    int m_v;
    bit m_hs;
    bit m_acc;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = pick(bus.req_valid_i, m_ptr);
        if (w >= 0 && (exp_q.size() == 0 || bus.out_ready_i)) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            m_hs  = (exp_q.size() != 0) && bus.out_ready_i;
            m_w   = pick(bus.req_valid_i, m_ptr);
            m_acc = (m_w >= 0) && (exp_q.size() == 0 || bus.out_ready_i);
            if (bus.cnt_clr_i) m_cnt = 0;
            else if (m_hs && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_hs) void'(exp_q.pop_front());
            if (m_acc) begin
                m_v = int'($signed(bus.req_data_i[m_w*8 +: 8]));
                if (bus.req_neg_i[m_w]) m_v = -m_v;
                exp_q.push_back({IDW'(m_w), m_v[8:0]});
                m_ptr = (m_w + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", 32'(bus.out_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("out_data", 32'(bus.out_data_o), 32'(exp_q[0][8:0]));
            check("out_id", 32'(bus.out_id_o), 32'(exp_q[0][IDW+8:9]));
        end
        check("txn_cnt", 32'(bus.txn_cnt_o), 32'(m_cnt));
        check("req_ready", 32'(bus.req_ready_o), 32'(exp_ready()));
    end

    task automatic set_in(input logic [N-1:0] v, input logic [31:0] d,
                          input logic [N-1:0] ng, input logic ordy);
        bus.req_valid_i = v;
        bus.req_data_i  = d;
        bus.req_neg_i   = ng;
        bus.out_ready_i = ordy;
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        next();
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
    endtask

    logic [7:0] sw_data[5] = '{8'h80, 8'h00, 8'hFF, 8'h80, 8'h7F};
    logic       sw_neg[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] sw_exp[5]  = '{9'h080, 9'h000, 9'h001, 9'h180, 9'h07F};

    initial begin
        bus.cnt_clr_i = 1'b0;
        set_in('0, '0, '0, 1'b0);
        #1;
        check("rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_data", 32'(bus.out_data_o), 32'd0);
        check("rst_id", 32'(bus.out_id_o), 32'd0);
        check("rst_cnt", 32'(bus.txn_cnt_o), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single request: -(1) = 9'h1FF
        set_in(4'b0001, 32'h01, 4'b0001, 1'b1);
        #1;
        check("single_ready", 32'(bus.req_ready_o), 32'h1);
        next();
        set_in('0, '0, '0, 1'b1);
        check("single_valid", 32'(bus.out_valid_o), 32'd1);
        check("single_data", 32'(bus.out_data_o), 32'h1FF);
        check("single_id", 32'(bus.out_id_o), 32'd0);
        next();
        check("single_cnt", 32'(bus.txn_cnt_o), 32'd1);
        check("single_drained", 32'(bus.out_valid_o), 32'd0);

        for (int i = 0; i < 5; i++) begin
            set_in(4'b0001, 32'(sw_data[i]), {3'b000, sw_neg[i]}, 1'b1);
            next();
            check("sweep_data", 32'(bus.out_data_o), 32'(sw_exp[i]));
        end

        // All requesters valid: ids rotate one result per cycle.
        reset_dut();
        set_in(4'b1111, 32'h04030201, 4'b0000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            next();
            check("rr_id", 32'(bus.out_id_o), 32'(k % 4));
            check("rr_data", 32'(bus.out_data_o), 32'(k % 4 + 1));
        end

        // Backpressure while holding the requester-3 result.
        bus.out_ready_i = 1'b0;
        #1;
        check("bp_ready", 32'(bus.req_ready_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            next();
            check("bp_id", 32'(bus.out_id_o), 32'd3);
            check("bp_data", 32'(bus.out_data_o), 32'h004);
            check("bp_ready", 32'(bus.req_ready_o), 32'd0);
        end
        bus.out_ready_i = 1'b1;
        next();
        check("bp_resume_id", 32'(bus.out_id_o), 32'd0);

        // Reset while the slot is full and the pointer sits at 2.
        reset_dut();
        set_in(4'b0010, 32'h00001100, 4'b0000, 1'b0);
        next();
        set_in(4'b0101, 32'h00550022, 4'b0000, 1'b0);
        next();
        check("hold_id", 32'(bus.out_id_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid_o), 32'd0);
        next();
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        #1;
        check("postrst_valid", 32'(bus.out_valid_o), 32'd0);
        check("postrst_ready", 32'(bus.req_ready_o), 32'h1);
        next();
        check("postrst_id", 32'(bus.out_id_o), 32'd0);
        check("postrst_data", 32'(bus.out_data_o), 32'h022);

        // Saturation, then a clear that coincides with a handshake.
        bus.cnt_clr_i = 1'b1;
        set_in(4'b0001, 32'h05, 4'b0000, 1'b1);
        next();
        bus.cnt_clr_i = 1'b0;
        repeat (65540) next();
        check("sat_cnt", 32'(bus.txn_cnt_o), 32'hFFFF);
        next();
        check("sat_hold", 32'(bus.txn_cnt_o), 32'hFFFF);
        bus.cnt_clr_i = 1'b1;
        next();
        bus.cnt_clr_i = 1'b0;
        check("clr_cnt", 32'(bus.txn_cnt_o), 32'd0);
        next();
        check("clr_restart", 32'(bus.txn_cnt_o), 32'd1);

        set_in('0, '0, '0, 1'b1);
        next();
        next();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
